sysid_check_master: RTL

Avalon-MM read master that interrogates the system-ID control slave over its two-word register map (word 0 = system ID, word 1 = build timestamp) and compares both words against build-time expected values. It sits beside the Nios/host interconnect and gives board-bring-up logic and the host a hardware pass/fail indication. The indication is held until the next check is requested.

---
 rtl/sysid_check_master.sv | 79 +++++++
 1 files changed

// File: rtl/sysid_check_master.sv
// sysid_check_master: Avalon-MM read master that fetches the system-ID and build-timestamp
// words, compares them against build-time constants and holds a sticky pass/fail result.
module sysid_check_master #(
    parameter logic [31:0] EXPECTED_ID    = 32'd1478765543,
    parameter logic [31:0] EXPECTED_TS    = 32'd1309222362,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout,
    output logic [31:0] read_id,
    output logic [31:0] read_ts,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);
    typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, CMP} state_t;
    localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);
    state_t      state;
    logic [15:0] stall;
    logic        expired;
    // Bus strobes come straight from the state register so they cannot glitch on inputs.
    assign busy        = state != IDLE;
    assign done        = state == CMP;
    assign avm_read    = state == RD_ID || state == RD_TS;
    assign avm_address = state == RD_TS;
    assign expired     = TIMEOUT_CYCLES != 0 && stall == STALL_LAST;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            stall       <= '0;
            pass        <= 1'b0;
            id_mismatch <= 1'b0;
            ts_mismatch <= 1'b0;
            timeout     <= 1'b0;
            read_id     <= '0;
            read_ts     <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state       <= RD_ID;
                    stall       <= '0;
                    pass        <= 1'b0;
                    id_mismatch <= 1'b0;
                    ts_mismatch <= 1'b0;
                    timeout     <= 1'b0;
                    read_id     <= '0;
                    read_ts     <= '0;
                end
                RD_ID, RD_TS: if (!avm_waitrequest) begin
                    if (state == RD_ID) read_id <= avm_readdata;
                    else read_ts <= avm_readdata;
                    stall <= '0;
                    state <= state == RD_ID ? RD_TS : CMP;
                end else if (expired) begin
                    timeout <= 1'b1;
                    stall   <= '0;
                    state   <= CMP;
                end else begin
                    stall <= stall + 16'd1;
                end
                CMP: begin
                    id_mismatch <= read_id != EXPECTED_ID;
                    ts_mismatch <= read_ts != EXPECTED_TS;
                    pass        <= !timeout && read_id == EXPECTED_ID && read_ts == EXPECTED_TS;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
